// File: rtl/data_mem_pipe.sv
// data_mem_pipe: data memory with pipelined reads, hardware clear engine and Ready/DataValid handshake.
module data_mem_pipe #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int DEPTH         = 256,
  parameter int RD_LAT        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              ReadMem,
  input  logic              WriteMem,
  input  logic [ADDR_W-1:0] DataAddress,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              ClearMem,
  output logic              Ready,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataValid,
  output logic              AddrErr
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  logic in_range, clr_acc, rd_acc, wr_acc;
  logic v1, v2, e1, e2, we;
  logic [DATA_W-1:0] d1, d2;
  assign idx      = DataAddress[IW-1:0];
  assign in_range = {1'b0, DataAddress} < (ADDR_W+1)'(DEPTH);
  assign Ready    = state == READY && Reset_n;
  assign clr_acc  = Ready & ClearMem;
  assign rd_acc   = Ready & ReadMem & ~ClearMem;
  assign wr_acc   = Ready & WriteMem & ~ClearMem;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == INIT) begin
      cnt_n = cnt + 1'b1;
      if (cnt == CW'(DEPTH - 1)) begin
        state_n = READY;
        cnt_n   = '0;
      end
    end else if (clr_acc) begin
      state_n = INIT;
      cnt_n   = '0;
    end
  end
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= INIT_ON_RESET != 0 ? INIT : READY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_ff @(posedge clk)
    if (state == INIT) mem[cnt[IW-1:0]] <= '0;
    else if (wr_acc && in_range) mem[idx] <= DataIn;
  // A same-cycle out-of-range read already raises AddrErr, so the write's pulse is suppressed.
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) begin
      {v1, v2, e1, e2, we} <= '0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      v1 <= rd_acc;
      d1 <= rd_acc && in_range ? mem[idx] : '0;
      e1 <= rd_acc & ~in_range;
      v2 <= v1;
      d2 <= d1;
      e2 <= e1;
      we <= wr_acc & ~in_range & ~rd_acc;
    end
  assign DataValid = RD_LAT == 2 ? v2 : v1;
  assign DataOut   = RD_LAT == 2 ? d2 : d1;
  assign AddrErr   = (RD_LAT == 2 ? e2 : e1) | we;
endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: drives a full-depth RD_LAT=1 instance and a DEPTH=200 RD_LAT=2 instance in lockstep
// and compares every cycle against an array-and-schedule reference model.
module tb_data_mem_pipe;
  logic clk = 0, Reset_n = 0, ReadMem = 0, WriteMem = 0, ClearMem = 0;
  logic [7:0] DataAddress = 0, DataIn = 0;
  logic ra, va, ea, rb, vb, eb;
  logic [7:0] da, db;
  int checks = 0, errors = 0;
  int dep [2] = '{256, 200};
  int lat [2] = '{1, 2};
  bit [7:0] mm [2][256];
  int init_left [2];
  bit ev [2][4];
  bit ee [2][4];
  bit [7:0] ed [2][4];
  int cur;

  always #5 clk = ~clk;

  data_mem_pipe #(.DEPTH(256), .RD_LAT(1)) dut_a (
    .clk(clk), .Reset_n(Reset_n), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .DataAddress(DataAddress), .DataIn(DataIn), .ClearMem(ClearMem),
    .Ready(ra), .DataOut(da), .DataValid(va), .AddrErr(ea));
  data_mem_pipe #(.DEPTH(200), .RD_LAT(2)) dut_b (
    .clk(clk), .Reset_n(Reset_n), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .DataAddress(DataAddress), .DataIn(DataIn), .ClearMem(ClearMem),
    .Ready(rb), .DataOut(db), .DataValid(vb), .AddrErr(eb));

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d observed %0h expected %0h", tag, cur, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur = 0;
    for (int i = 0; i < 2; i++) begin
      init_left[i] = dep[i];
      for (int s = 0; s < 4; s++) begin
        ev[i][s] = 0;
        ee[i][s] = 0;
        ed[i][s] = 0;
      end
    end
  endtask

  // Called at a falling edge: check outputs of the last rising edge, then drive and model the next one.
  task automatic step(bit rd, bit wr, bit clr, bit [7:0] a, bit [7:0] d);
    int s;
    bit oor;
    s = cur % 4;
    chk("ready_a", 8'(ra), 8'(init_left[0] == 0));
    chk("valid_a", 8'(va), 8'(ev[0][s]));
    chk("data_a", da, ed[0][s]);
    chk("err_a", 8'(ea), 8'(ee[0][s]));
    chk("ready_b", 8'(rb), 8'(init_left[1] == 0));
    chk("valid_b", 8'(vb), 8'(ev[1][s]));
    chk("data_b", db, ed[1][s]);
    chk("err_b", 8'(eb), 8'(ee[1][s]));
    ReadMem = rd;
    WriteMem = wr;
    ClearMem = clr;
    DataAddress = a;
    DataIn = d;
    for (int i = 0; i < 2; i++) begin
      ev[i][s] = 0;
      ee[i][s] = 0;
      ed[i][s] = 0;
      oor = int'(a) >= dep[i];
      if (init_left[i] > 0) begin
        init_left[i]--;
        if (init_left[i] == 0) for (int k = 0; k < 256; k++) mm[i][k] = 0;
      end else if (clr) init_left[i] = dep[i];
      else begin
        if (rd) begin
          ev[i][(cur + lat[i]) % 4] = 1;
          ed[i][(cur + lat[i]) % 4] = oor ? 8'h00 : mm[i][a];
          if (oor) ee[i][(cur + lat[i]) % 4] = 1;
        end
        if (wr) begin
          if (!oor) mm[i][a] = d;
          else if (!rd) ee[i][(cur + 1) % 4] = 1;
        end
      end
    end
    cur++;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    Reset_n = 0;
    ReadMem = 0;
    WriteMem = 0;
    ClearMem = 0;
    #1;
    chk("rst_ready_a", 8'(ra), 8'h00);
    chk("rst_valid_a", 8'(va), 8'h00);
    chk("rst_data_a", da, 8'h00);
    chk("rst_err_a", 8'(ea), 8'h00);
    chk("rst_ready_b", 8'(rb), 8'h00);
    chk("rst_valid_b", 8'(vb), 8'h00);
    chk("rst_data_b", db, 8'h00);
    chk("rst_err_b", 8'(eb), 8'h00);
    @(negedge clk);
    @(negedge clk);
    Reset_n = 1;
    model_reset();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    idle(258);
    step(1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'h7F, 8'h00);
    step(1, 0, 0, 8'hFF, 8'h00);
    idle(3);
    step(0, 1, 0, 8'h10, 8'hA5);
    step(1, 0, 0, 8'h10, 8'h00);
    idle(3);
    step(0, 1, 0, 8'h20, 8'h11);
    step(1, 1, 0, 8'h20, 8'h22);
    step(1, 0, 0, 8'h20, 8'h00);
    idle(3);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(i), 8'(8'h30 + i));
    idle(2);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(i), 8'h00);
    idle(3);
    step(0, 1, 0, 8'h05, 8'h3C);
    step(1, 0, 0, 8'h05, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00);
    idle(258);
    step(1, 0, 0, 8'h05, 8'h00);
    idle(3);
    step(0, 1, 0, 8'hC8, 8'h99);
    idle(2);
    step(1, 0, 0, 8'hC8, 8'h00);
    idle(3);
    step(1, 1, 0, 8'hE0, 8'h44);
    idle(3);
    step(1, 1, 1, 8'h07, 8'h55);
    idle(258);
    step(1, 0, 0, 8'h07, 8'h00);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0,
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    idle(258);
    step(0, 1, 0, 8'h05, 8'h3C);
    step(1, 0, 0, 8'h05, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00);
    idle(20);
    step(1, 0, 0, 8'h05, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00);
    do_reset();
    idle(260);
    step(1, 0, 0, 8'h05, 8'h00);
    step(1, 0, 0, 8'hC7, 8'h00);
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
